// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO memory write port among NUM_REQ producers.
// Each grant allows a burst of up to MAX_BURST words, followed by a one-cycle arbitration bubble.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          full_i,
  output logic                          mem_w_en_o,
  output logic [DATA_WIDTH-1:0]         mem_data_in_o,
  output logic [ID_WIDTH-1:0]           gnt_id_o,
  output logic                          busy_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q;
  logic [ID_WIDTH-1:0] gnt_id_q;
  logic [ID_WIDTH-1:0] last_id_q;
  logic [7:0]          burst_cnt_q;

  logic                grant_s;
  logic                gnt_valid_s;
  logic                wen_s;
  logic                pick_found_s;
  logic [ID_WIDTH-1:0] pick_id_s;
  logic [ID_WIDTH-1:0] cand_s;
  logic                hit_s;
  logic [NUM_REQ-1:0]  req_ready_s;

  // Reset overrides the grant combinationally so nothing is written while rst is high.
  assign grant_s     = (state_q == GRANT) && !rst_i;
  assign gnt_valid_s = req_valid_i[gnt_id_q];
  assign wen_s       = grant_s && gnt_valid_s && !full_i;

  // Round-robin search starting just after the last grantee, wrapping at NUM_REQ-1.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = last_id_q;
    hit_s        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s       = (cand_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cand_s + ID_WIDTH'(1);
      hit_s        = !pick_found_s && req_valid_i[cand_s];
      pick_id_s    = hit_s ? cand_s : pick_id_s;
      pick_found_s = pick_found_s | hit_s;
    end
  end

  // Only the grantee sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready_s = '0;
    if (grant_s) begin
      req_ready_s[gnt_id_q] = !full_i;
    end else begin
      req_ready_s = '0;
    end
  end

  assign req_ready_o   = req_ready_s;
  assign mem_w_en_o    = wen_s;
  assign mem_data_in_o = grant_s ? req_data_i[gnt_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign gnt_id_o      = gnt_id_q;
  assign busy_o        = grant_s;

  // Grant state machine: arbitrate in IDLE, count burst words in GRANT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      last_id_q   <= ID_WIDTH'(NUM_REQ - 1);
      burst_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found_s) begin
            gnt_id_q    <= pick_id_s;
            burst_cnt_q <= 8'd0;
            state_q     <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (!gnt_valid_s) begin
            last_id_q <= gnt_id_q;
            state_q   <= IDLE;
          end else if (wen_s) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
            if (burst_cnt_q == 8'(MAX_BURST - 1)) begin
              last_id_q <= gnt_id_q;
              state_q   <= IDLE;
            end else begin
              state_q <= GRANT;
            end
          end else begin
            state_q <= GRANT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO memory write port among NUM_REQ producers, all in the FIFO write clock domain.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time and lets it write a burst of up to MAX_BURST words.
- It drives the memory's write enable and write data, and backpressures every producer when the FIFO reports full.
- It sits between the producers and the FIFO memory plus write-pointer logic. The write pointer advances on mem_w_en.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8).
- DATA_WIDTH, 8, word width; matches the FIFO memory.
- MAX_BURST, 4, maximum number of consecutive writes per grant (1..255).
- ID_WIDTH, 2, width of the grant index; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  write-domain clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-producer valid; bit i belongs to producer i.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer ready; a transfer occurs when valid and ready are both high.
- full  input  1  FIFO full flag from the write-pointer logic.
- mem_w_en  output  1  write enable to the FIFO memory.
- mem_data_in  output  DATA_WIDTH  write data to the FIFO memory.
- gnt_id  output  ID_WIDTH  index of the current grantee; valid while busy is high.
- busy  output  1  high while the arbiter is in GRANT.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- State machine, two states:
  - IDLE: no grant.
  - GRANT: one producer owns the write port.
- Registered state: state, gnt_id, last_id, burst_cnt (8 bits).
- Reset values: state=IDLE, gnt_id=0, last_id=NUM_REQ-1 (so producer 0 has first priority after reset), burst_cnt=0.
- Outputs during and after reset:
  - busy=0, req_ready=0, mem_w_en=0, mem_data_in=0.
  - Reset asserted mid-burst drops the grant on the next edge. No write occurs in the cycle where rst is high, because mem_w_en is forced to 0.
- Transitions out of IDLE:
  - If any req_valid bit is set, choose the first set bit searching from last_id+1 upward, wrapping modulo NUM_REQ.
  - Load gnt_id with that index, clear burst_cnt, go to GRANT.
  - The arbitration cycle itself makes no transfer, so there is a 1-cycle bubble per grant.
- Combinational outputs in GRANT:
  - req_ready[gnt_id] = !full; every other req_ready bit = 0.
  - mem_w_en = req_valid[gnt_id] & !full & !rst.
  - mem_data_in = req_data slice gnt_id when in GRANT; 0 otherwise.
  - busy = 1.
- Transfer: a transfer is a cycle with mem_w_en=1. On a transfer burst_cnt increments.
- Leaving GRANT (last_id := gnt_id, go to IDLE) happens on either condition:
  - A transfer occurs with burst_cnt == MAX_BURST-1 (burst limit reached).
  - req_valid[gnt_id]=0 in a GRANT cycle (producer released). A valid drop ends the grant even after 0 transfers.
- Full in GRANT: while full=1 the grant holds, burst_cnt holds, and no release happens due to full. The arbiter releases only if the producer drops valid.
- Simultaneous requests: only the grantee is ever ready. Other producers must hold valid and data stable until they are granted.
- Fairness: after a grant to producer k ends, the next search starts at k+1. With all producers requesting continuously, the grant order is 0,1,2,3,0,...
- Worst-case wait for a requester with full=0 is (NUM_REQ-1)*(MAX_BURST+1) cycles.
- mem_w_en is never high while full=1. The memory also gates on full; this is defence in depth.
- Width rule: gnt_id and last_id wrap modulo NUM_REQ, not modulo 2^ID_WIDTH. The next-index increment uses an explicit compare with NUM_REQ-1.

Test Plan:
- Reset then single requester: rst for 2 cycles, then req_valid=4'b0100 held with data 0xA0..0xA5 -> one IDLE cycle, gnt_id=2; writes 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; busy drops; one IDLE cycle; re-grant to 2; writes 0xA4,0xA5.
- Round-robin, all requesting: req_valid=4'b1111, full=0, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant has exactly 4 writes followed by a 1-cycle bubble; 20 writes in 25 cycles.
- Full backpressure: producer 1 granted; full=1 for 3 cycles after its 2nd write -> mem_w_en=0 and req_ready=0 during those 3 cycles; burst_cnt stays at 2; after full=0, 2 more writes, then release.
- Early release: producer 3 sends 1 word, then drops valid while producer 0 is requesting -> producer 3 writes 1 word; the next cycle is IDLE with last_id=3; then gnt_id=0.
- Reset mid-burst: rst=1 after the 2nd write of producer 2 -> mem_w_en=0 in that cycle; the next cycle shows state IDLE and last_id=3; after release, producer 0 wins over producer 2 if both request.
- Non-granted isolation: producers 0 and 2 both valid, producer 0 granted -> req_ready[2]=0 throughout and mem_data_in always equals producer 0's data while mem_w_en=1.
